memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive data grants issued while any instruction request is pending.
REQ-002 SHALL have port CLK, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port iREN, input, 2 bits, instruction read request per core (index = core id).
REQ-005 SHALL have port iaddr, input, 2x32 bits, instruction address per core.
REQ-006 SHALL have port iwait, output, 2 bits, high = instruction request not complete this cycle.
REQ-007 SHALL have port iload, output, 2x32 bits, instruction read data per core.
REQ-008 SHALL have port dREN, input, 2 bits, data read request per core.
REQ-009 SHALL have port dWEN, input, 2 bits, data write request per core.
REQ-010 SHALL have port daddr, input, 2x32 bits, data address per core.
REQ-011 SHALL have port dstore, input, 2x32 bits, data write value per core.
REQ-012 SHALL have port dwait, output, 2 bits, high = data request not complete this cycle.
REQ-013 SHALL have port dload, output, 2x32 bits, data read data per core.
REQ-014 SHALL have RAM-side ports ramaddr (output, 32), ramstore (output, 32), ramREN (output, 1), ramWEN (output, 1), ramload (input, 32) and ramstate (input, 2, ramstate_t: FREE, BUSY, ACCESS, ERROR).

Function
REQ-015 SHALL be a two-state FSM: IDLE, then OWN with the granted requester latched in an owner register (type, core).
REQ-016 SHALL in IDLE grant data requests (dREN or dWEN) before instruction requests, unless the starvation counter equals STARVE_LIMIT and an iREN is pending; then an instruction request is granted.
REQ-017 SHALL break ties within a class with a per-class round-robin pointer: the pointer core wins, and after a completed grant the pointer moves to the other core.
REQ-018 SHALL move IDLE to OWN on the edge after a grant decision, so RAM signals assert one cycle after the request is first seen in IDLE.
REQ-019 SHALL in OWN drive ramaddr, ramstore, ramREN and ramWEN from the owner's live inputs; for a data owner with dREN and dWEN both high, only ramWEN is asserted.
REQ-020 SHALL in any cycle with ramstate == ACCESS in OWN drop the owner's wait for exactly that cycle, pass ramload to the owner's load port, and return to IDLE on the next edge.
REQ-021 SHALL in OWN, if the owner deasserts its request before ACCESS, abort to IDLE with the pointer and counter unchanged and all RAM controls low next cycle.
REQ-022 SHALL treat ramstate ERROR or BUSY in OWN as not complete: stay in OWN and keep the wait high.
REQ-023 SHALL in IDLE drive all RAM controls low and ramaddr/ramstore to 0.
REQ-024 SHALL hold every wait bit high except the single completing bit; load ports not owning the bus SHALL carry ramload.
REQ-025 SHALL increment the starvation counter (saturating at STARVE_LIMIT) on each completed data grant while any iREN is pending, and clear it on a completed instruction grant or when no iREN is pending.

Reset
REQ-026 SHALL on RST high immediately set the state to IDLE, both pointers to core 0, the counter to 0, RAM controls and ramaddr/ramstore to 0, and iwait/dwait to 2'b11.
REQ-027 SHALL on reset mid-OWN abandon the transaction with no completion pulse to any requester.

Structure
REQ-028 SHALL place ramstate_t, word_t and the owner type enum in the shared cpu_types_pkg.
REQ-029 SHALL implement both per-class round-robin choices with one sub-module, rr_pick2 (2-bit request vector plus pointer in, one-hot grant out), instantiated twice.

Verification
REQ-030 SHALL test a single request: iREN[0]=1, iaddr[0]=0x40, RAM ACCESS after 2 cycles -> ramREN asserted in cycle 1, iwait[0] low for one cycle, iload[0]=ramload.
REQ-031 SHALL test priority: dREN[1] and iREN[0] raised together -> core 1 data granted first, instruction served next.
REQ-032 SHALL test round-robin: dWEN[0] and dREN[1] held continuously -> grants alternate 0,1,0,1; the core-0 write has ramWEN=1 and ramstore=dstore[0].
REQ-033 SHALL test starvation: both cores stream data while iREN[1] is held, STARVE_LIMIT=4 -> iREN[1] granted after exactly 4 data completions.
REQ-034 SHALL test abort: dREN[0] dropped while ramstate is BUSY -> IDLE next cycle, dwait[0] never low, pointer unchanged.
REQ-035 SHALL test reset mid-OWN: assert RST while ramstate is BUSY -> outputs at reset values that cycle, no wait pulse.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, data word, bus owner.
// Imported by the memory arbiter and its helpers.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_kind_t;

  typedef struct packed {
    owner_kind_t kind;
    logic        core;
  } owner_t;

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: req (2b), ptr (favoured core) -> gnt (one-hot).
// The pointer core wins when requesting, otherwise the other core.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    if (req[ptr]) begin
      gnt[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      gnt[~ptr] = 1'b1;
    end
  end
endmodule

// File: rtl/memory_arbiter.sv
// Two-core I/D memory arbiter onto one RAM port; data before instruction
// with starvation guard. Ports: CLK/RST, per-core i*/d* buses, ram* side.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [1:0]      iREN,
  input  word_t [1:0]     iaddr,
  output logic [1:0]      iwait,
  output word_t [1:0]     iload,
  input  logic [1:0]      dREN,
  input  logic [1:0]      dWEN,
  input  word_t [1:0]     daddr,
  input  word_t [1:0]     dstore,
  output logic [1:0]      dwait,
  output word_t [1:0]     dload,
  output word_t           ramaddr,
  output word_t           ramstore,
  output logic            ramREN,
  output logic            ramWEN,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state, state_n;
  owner_t        own, own_n;
  logic          iptr, iptr_n;
  logic          dptr, dptr_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [1:0] dreq;
  logic [1:0] ignt, dgnt;
  logic       own_live;
  logic       done;

  assign dreq = dREN | dWEN;

  rr_pick2 u_ipick (
    .req(iREN),
    .ptr(iptr),
    .gnt(ignt)
  );

  rr_pick2 u_dpick (
    .req(dreq),
    .ptr(dptr),
    .gnt(dgnt)
  );

  always_comb begin
    if (own.kind == OWN_D) begin
      own_live = dREN[own.core] | dWEN[own.core];
    end else begin
      own_live = iREN[own.core];
    end
  end

  assign done = (state == OWN) && own_live &&
                (ramstate == ACCESS);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      own   <= '0;
      iptr  <= 1'b0;
      dptr  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      own   <= own_n;
      iptr  <= iptr_n;
      dptr  <= dptr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    own_n   = own;
    iptr_n  = iptr;
    dptr_n  = dptr;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        priority case (1'b1)
          (cnt == LIMIT) && (|iREN): begin
            state_n   = OWN;
            own_n     = '{kind: OWN_I, core: ignt[1]};
          end
          |dreq: begin
            state_n   = OWN;
            own_n     = '{kind: OWN_D, core: dgnt[1]};
          end
          |iREN: begin
            state_n   = OWN;
            own_n     = '{kind: OWN_I, core: ignt[1]};
          end
          default: ;
        endcase
      end
      OWN: begin
        // a dropped request abandons the slot without side effects
        if (!own_live) begin
          state_n = IDLE;
        end else if (done) begin
          state_n = IDLE;
          if (own.kind == OWN_D) begin
            dptr_n = ~own.core;
            if (!(|iREN)) begin
              cnt_n = '0;
            end else if (cnt != LIMIT) begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            iptr_n = ~own.core;
            cnt_n  = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    iwait    = 2'b11;
    dwait    = 2'b11;
    if (state == OWN) begin
      if (own.kind == OWN_D) begin
        ramaddr  = daddr[own.core];
        ramstore = dstore[own.core];
        ramWEN   = dWEN[own.core];
        // write wins when a core raises both
        ramREN   = dREN[own.core] & ~dWEN[own.core];
        if (done) dwait[own.core] = 1'b0;
      end else begin
        ramaddr = iaddr[own.core];
        ramREN  = iREN[own.core];
        if (done) iwait[own.core] = 1'b0;
      end
    end
  end

  assign iload = {ramload, ramload};
  assign dload = {ramload, ramload};
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int LIM = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] iREN, iwait, dREN, dWEN, dwait;
  word_t [1:0] iaddr, iload, daddr, dstore, dload;
  word_t      ramaddr, ramstore, ramload;
  logic       ramREN, ramWEN;
  ramstate_t  ramstate;

  always #5 CLK = ~CLK;

  memory_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate)
  );

  // stimulus shadows, applied at each falling edge
  logic       n_rst;
  logic [1:0] n_iren, n_dren, n_dwen;
  word_t [1:0] n_iaddr, n_daddr, n_dstore;
  word_t      n_ramload;
  ramstate_t  n_rs;
  bit         ram_auto, stream;
  int         lat, act_cnt;

  typedef struct {
    int    cls;
    int    core;
    logic  wen;
    word_t store;
  } ev_t;
  ev_t log_q[$];

  int vectors = 0;
  int errs = 0;

  logic [1:0] s_iwait, s_dwait;
  logic       s_ren, s_wen;
  word_t      s_addr, s_iload0;

  // model: who holds the bus, class pointers, starvation count
  bit m_busy;
  int m_cls, m_core, m_cnt;
  int m_ptr[2];

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic rq(int cls, int c);
    if (cls != 0) return dREN[c] | dWEN[c];
    return iREN[c];
  endfunction

  function automatic int pickc(int cls);
    int p = m_ptr[cls];
    return rq(cls, p) ? p : 1 - p;
  endfunction

  function automatic int code(int i);
    if (i >= log_q.size()) return -1;
    return log_q[i].cls * 2 + log_q[i].core;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_ptr[0] = 0;
    m_ptr[1] = 0;
    m_cnt = 0;
    act_cnt = 0;
  endtask

  task automatic model_step();
    bit ip, dp;
    ip = iREN != 2'b00;
    dp = (dREN | dWEN) != 2'b00;
    if (!m_busy) begin
      if (ip && m_cnt == LIM) begin m_busy = 1; m_cls = 0; end
      else if (dp) begin m_busy = 1; m_cls = 1; end
      else if (ip) begin m_busy = 1; m_cls = 0; end
      if (m_busy) m_core = pickc(m_cls);
    end else if (!rq(m_cls, m_core)) begin
      m_busy = 0;
    end else if (ramstate == ACCESS) begin
      m_busy = 0;
      m_ptr[m_cls] = 1 - m_core;
      if (m_cls == 0) m_cnt = 0;
      else if (ip) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
      else m_cnt = 0;
    end
  endtask

  task automatic compare();
    word_t e_addr, e_store;
    logic e_ren, e_wen;
    logic [1:0] e_iw, e_dw;
    int c;
    e_addr = '0; e_store = '0; e_ren = 0; e_wen = 0;
    e_iw = 2'b11; e_dw = 2'b11;
    if (m_busy) begin
      c = m_core;
      if (m_cls != 0) begin
        e_addr = daddr[c];
        e_store = dstore[c];
        e_wen = dWEN[c];
        e_ren = dREN[c] && !dWEN[c];
      end else begin
        e_addr = iaddr[c];
        e_ren = iREN[c];
      end
      if (rq(m_cls, c) && ramstate == ACCESS) begin
        if (m_cls != 0) e_dw[c] = 1'b0;
        else e_iw[c] = 1'b0;
      end
    end
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    chk("iwait", iwait, e_iw);
    chk("dwait", dwait, e_dw);
    chk("iload", iload, {ramload, ramload});
    chk("dload", dload, {ramload, ramload});
    s_iwait = iwait; s_dwait = dwait;
    s_ren = ramREN; s_wen = ramWEN;
    s_addr = ramaddr; s_iload0 = iload[0];
    for (int k = 0; k < 2; k++) begin
      if (!iwait[k]) log_q.push_back('{0, k, ramWEN, ramstore});
      if (!dwait[k]) log_q.push_back('{1, k, ramWEN, ramstore});
    end
  endtask

  task automatic cycle();
    bit act, dn;
    @(negedge CLK);
    RST = n_rst;
    iREN = n_iren; dREN = n_dren; dWEN = n_dwen;
    iaddr = n_iaddr; daddr = n_daddr; dstore = n_dstore;
    ramload = n_ramload;
    if (RST) model_reset();
    #1;
    if (ram_auto)
      ramstate = (ramREN | ramWEN) ?
                 ((act_cnt >= lat) ? ACCESS : BUSY) : FREE;
    else
      ramstate = n_rs;
    #1;
    compare();
    act = ramREN | ramWEN;
    dn = (iwait != 2'b11) || (dwait != 2'b11);
    for (int k = 0; k < 2; k++) begin
      if (!iwait[k]) n_iren[k] = 1'b0;
      if (!dwait[k] && !stream) begin
        n_dren[k] = 1'b0;
        n_dwen[k] = 1'b0;
      end
    end
    @(posedge CLK);
    if (!RST) begin
      model_step();
      act_cnt = (act && !dn) ? act_cnt + 1 : 0;
    end
  endtask

  task automatic clear_reqs();
    n_iren = 2'b00; n_dren = 2'b00; n_dwen = 2'b00;
  endtask

  task automatic do_reset();
    clear_reqs();
    n_rst = 1'b1;
    cycle();
    n_rst = 1'b0;
    cycle();
    log_q.delete();
  endtask

  initial begin
    n_rst = 1'b1;
    clear_reqs();
    n_iaddr = '0; n_daddr = '0; n_dstore = '0;
    n_ramload = 32'h0; n_rs = FREE;
    ram_auto = 1; stream = 0; lat = 0; act_cnt = 0;
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;

    cycle();
    chk("rst_iwait", s_iwait, 2'b11);
    chk("rst_dwait", s_dwait, 2'b11);
    chk("rst_ramctl", {s_ren, s_wen}, 2'b00);
    chk("rst_ramaddr", s_addr, 32'h0);
    n_rst = 1'b0;
    cycle();

    // single instruction fetch, RAM answers on the second OWN cycle
    lat = 1;
    n_iaddr[0] = 32'h40;
    n_ramload = 32'hCAFE_0001;
    n_iren = 2'b01;
    cycle();
    chk("single_c0_ren", s_ren, 1'b0);
    cycle();
    chk("single_c1_ren", s_ren, 1'b1);
    chk("single_c1_addr", s_addr, 32'h40);
    chk("single_c1_iwait", s_iwait, 2'b11);
    cycle();
    chk("single_c2_iwait", s_iwait, 2'b10);
    chk("single_c2_iload", s_iload0, 32'hCAFE_0001);
    cycle();
    chk("single_c3_iwait", s_iwait, 2'b11);

    // data beats instruction
    do_reset();
    lat = 0;
    n_daddr[1] = 32'h100;
    n_dren = 2'b10;
    n_iren = 2'b01;
    repeat (6) cycle();
    chk("prio_first", code(0), 3);
    chk("prio_second", code(1), 0);

    // round robin between a core-0 write and a core-1 read
    do_reset();
    stream = 1;
    n_dstore[0] = 32'h1234_5678;
    n_daddr[0] = 32'h200;
    n_daddr[1] = 32'h300;
    n_dwen = 2'b01;
    n_dren = 2'b10;
    repeat (8) cycle();
    chk("rr_0", code(0), 2);
    chk("rr_1", code(1), 3);
    chk("rr_2", code(2), 2);
    chk("rr_3", code(3), 3);
    if (log_q.size() > 1) begin
      chk("rr_wen0", log_q[0].wen, 1'b1);
      chk("rr_store0", log_q[0].store, 32'h1234_5678);
      chk("rr_wen1", log_q[1].wen, 1'b0);
    end else begin
      chk("rr_log_len", log_q.size(), 2);
    end

    // starvation guard lets the fetch in after LIM data beats
    do_reset();
    stream = 1;
    n_dren = 2'b11;
    n_iren = 2'b10;
    repeat (12) cycle();
    chk("starve_0", code(0), 2);
    chk("starve_1", code(1), 3);
    chk("starve_2", code(2), 2);
    chk("starve_3", code(3), 3);
    chk("starve_4", code(4), 1);
    stream = 0;

    // abort while RAM busy
    do_reset();
    lat = 100;
    n_dren = 2'b01;
    cycle();
    cycle();
    chk("abort_c1_ren", s_ren, 1'b1);
    n_dren = 2'b00;
    cycle();
    chk("abort_c2_dwait", s_dwait, 2'b11);
    cycle();
    chk("abort_c3_ren", s_ren, 1'b0);
    chk("abort_c3_dwait", s_dwait, 2'b11);
    chk("abort_no_done", log_q.size(), 0);
    lat = 0;
    n_dren = 2'b11;
    repeat (2) cycle();
    chk("abort_ptr_kept", code(0), 2);
    clear_reqs();
    repeat (2) cycle();

    // reset in the middle of an owned transaction
    do_reset();
    ram_auto = 0;
    n_rs = BUSY;
    n_daddr[1] = 32'hABC0;
    n_dren = 2'b10;
    cycle();
    cycle();
    chk("rmo_ren_before", s_ren, 1'b1);
    n_rst = 1'b1;
    cycle();
    chk("rmo_iwait", s_iwait, 2'b11);
    chk("rmo_dwait", s_dwait, 2'b11);
    chk("rmo_ramctl", {s_ren, s_wen}, 2'b00);
    chk("rmo_addr", s_addr, 32'h0);
    n_rst = 1'b0;
    clear_reqs();
    repeat (2) cycle();
    chk("rmo_no_done", log_q.size(), 0);

    // random traffic
    ram_auto = 0;
    for (int i = 0; i < 3000; i++) begin
      n_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 4) begin
        n_iren = 2'($urandom);
        n_dren = 2'($urandom) & 2'($urandom);
        n_dwen = 2'($urandom) & 2'($urandom);
      end
      n_iaddr[0] = $urandom; n_iaddr[1] = $urandom;
      n_daddr[0] = $urandom; n_daddr[1] = $urandom;
      n_dstore[0] = $urandom; n_dstore[1] = $urandom;
      n_ramload = $urandom;
      n_rs = ramstate_t'($urandom_range(0, 3));
      cycle();
    end
    log_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end
endmodule
